// File: rtl/quantum_challenge_pkg.sv
// Shared widths and state encoding for the challenge path into the quantum problem parser.
package quantum_challenge_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CHAL_W     = 1024;
  localparam int unsigned MOLECULE_W = 256;
  localparam int unsigned WORDS      = CHAL_W / WORD_W;
  localparam int unsigned COUNT_W    = 16;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } chal_state_e;

endpackage

// File: rtl/challenge_ack_timer.sv
// Acknowledge-wait timer: cleared on load, counts while running, expires unless an ack is present.
module challenge_ack_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int unsigned TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [TW-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (load) begin
      timer_q <= '0;
    end else if (run) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // An acknowledge in the final cycle beats expiry.
  assign expired = run && !ack && (timer_q == TW'(LIMIT - 1));

endmodule

// File: rtl/challenge_assembler.sv
// Packs a word stream into one challenge vector, strobes it to the parser and waits for its ack.
module challenge_assembler #(
  parameter int unsigned WORD_W      = quantum_challenge_pkg::WORD_W,
  parameter int unsigned CHAL_W      = quantum_challenge_pkg::CHAL_W,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [WORD_W-1:0]                      word_in,
  input  logic                                   word_valid,
  input  logic                                   word_last,
  output logic                                   word_ready,
  output logic [CHAL_W-1:0]                      global_challenges,
  output logic                                   challenge_valid,
  input  logic                                   molecule_ready,
  output logic [quantum_challenge_pkg::COUNT_W-1:0] challenge_count,
  output logic                                   ack_timeout
);

  import quantum_challenge_pkg::*;

  localparam int unsigned WORDS = CHAL_W / WORD_W;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if ((CHAL_W % WORD_W) != 0 || CHAL_W < MOLECULE_W) begin : g_bad_params
    $error("challenge_assembler: CHAL_W must be a multiple of WORD_W and hold a molecule");
  end

  chal_state_e        state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [CHAL_W-1:0]  fill_q, fill_d;
  logic [CHAL_W-1:0]  chal_q, chal_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               timer_load, timer_run, timer_expired;

  assign word_ready = (state_q == FILL) && reset_n;

  challenge_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .run     (timer_run),
    .ack     (molecule_ready),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    fill_d     = fill_q;
    chal_d     = chal_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    count_d    = count_q;
    timer_load = 1'b0;
    timer_run  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (word_valid && word_ready) begin
          fill_d[32'(wr_idx_q) * WORD_W +: WORD_W] = word_in;
          if (word_last || (wr_idx_q == IDX_W'(WORDS - 1))) begin
            // Slots above the last word are still clear from the previous completion.
            chal_d   = fill_d;
            fill_d   = '0;
            wr_idx_d = '0;
            valid_d  = 1'b1;
            state_d  = ISSUE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        timer_load = 1'b1;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        timer_run = 1'b1;
        if (molecule_ready) begin
          count_d = count_q + COUNT_W'(1);
          state_d = FILL;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FILL;
      wr_idx_q  <= '0;
      fill_q    <= '0;
      chal_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      fill_q    <= fill_d;
      chal_q    <= chal_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign global_challenges = chal_q;
  assign challenge_valid   = valid_q;
  assign challenge_count   = count_q;
  assign ack_timeout       = timeout_q;

endmodule

// File: tb/tb_challenge_assembler.sv
// Directed bench for challenge_assembler: fill, short, timeout, priority, reset and count wrap.
module tb_challenge_assembler;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CHAL_W = 1024;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_last = 1'b0;
  logic              word_ready;
  logic [CHAL_W-1:0] global_challenges;
  logic              challenge_valid;
  logic              molecule_ready = 1'b0;
  logic [15:0]       challenge_count;
  logic              ack_timeout;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [255:0] exp_mol;

  challenge_assembler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .word_in           (word_in),
    .word_valid        (word_valid),
    .word_last         (word_last),
    .word_ready        (word_ready),
    .global_challenges (global_challenges),
    .challenge_valid   (challenge_valid),
    .molecule_ready    (molecule_ready),
    .challenge_count   (challenge_count),
    .ack_timeout       (ack_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CHAL_W-1:0] got,
                       input logic [CHAL_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check("rst_word_ready", CHAL_W'(word_ready), '0);
    check("rst_chal", global_challenges, '0);
    check("rst_valid", CHAL_W'(challenge_valid), '0);
    check("rst_count", CHAL_W'(challenge_count), '0);
    check("rst_timeout", CHAL_W'(ack_timeout), '0);
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", CHAL_W'(word_ready), CHAL_W'(1));

    // Full 32-word fill, no word_last
    for (int i = 0; i < 32; i++) begin
      word_valid = 1'b1;
      word_in    = 32'(i + 1);
      tick();
      if (i == 30) check("full_no_early_strobe", CHAL_W'(challenge_valid), '0);
    end
    word_valid = 1'b0;
    check("full_strobe", CHAL_W'(challenge_valid), CHAL_W'(1));
    check("full_word0", CHAL_W'(global_challenges[31:0]), CHAL_W'(32'h1));
    check("full_word15", CHAL_W'(global_challenges[511:480]), CHAL_W'(32'h10));
    check("full_word31", CHAL_W'(global_challenges[1023:992]), CHAL_W'(32'h20));
    check("full_issue_not_ready", CHAL_W'(word_ready), '0);
    tick();
    check("full_strobe_single", CHAL_W'(challenge_valid), '0);
    molecule_ready = 1'b1;
    tick();
    molecule_ready = 1'b0;
    check("full_count", CHAL_W'(challenge_count), CHAL_W'(1));
    check("full_ready_back", CHAL_W'(word_ready), CHAL_W'(1));

    // Short 3-word challenge
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_in    = 32'hA + 32'(i);
      word_last  = (i == 2);
      tick();
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("short_strobe", CHAL_W'(challenge_valid), CHAL_W'(1));
    check("short_low", CHAL_W'(global_challenges[95:0]),
          CHAL_W'(96'h0000000C_0000000B_0000000A));
    check("short_high_zero", CHAL_W'(global_challenges[1023:96]), '0);
    tick();
    tick();
    check("short_wait_not_ready", CHAL_W'(word_ready), '0);
    check("short_strobe_single", CHAL_W'(challenge_valid), '0);
    molecule_ready = 1'b1;
    tick();
    molecule_ready = 1'b0;
    check("short_count", CHAL_W'(challenge_count), CHAL_W'(2));
    check("short_ready_back", CHAL_W'(word_ready), CHAL_W'(1));

    // Timeout: single-word challenge never acknowledged
    word_valid = 1'b1;
    word_in    = 32'h5;
    word_last  = 1'b1;
    tick();
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("tmo_single_word", CHAL_W'(global_challenges[63:0]), CHAL_W'(64'h5));
    tick();
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 14) begin
        check("tmo_no_early_pulse", CHAL_W'(ack_timeout), '0);
        check("tmo_wait_not_ready", CHAL_W'(word_ready), '0);
      end
    end
    check("tmo_pulse", CHAL_W'(ack_timeout), CHAL_W'(1));
    check("tmo_count_held", CHAL_W'(challenge_count), CHAL_W'(2));
    check("tmo_ready_back", CHAL_W'(word_ready), CHAL_W'(1));
    tick();
    check("tmo_pulse_single", CHAL_W'(ack_timeout), '0);

    // Backpressure with ack and expiry in the same cycle
    word_valid = 1'b1;
    word_in    = 32'h11;
    word_last  = 1'b1;
    tick();
    word_in = 32'h22;
    check("bp_strobe", CHAL_W'(challenge_valid), CHAL_W'(1));
    tick();
    for (int n = 1; n <= 15; n++) begin
      if (n == 15) molecule_ready = 1'b1;
      tick();
    end
    molecule_ready = 1'b0;
    check("prio_count", CHAL_W'(challenge_count), CHAL_W'(3));
    check("prio_no_timeout", CHAL_W'(ack_timeout), '0);
    check("bp_held_chal", CHAL_W'(global_challenges[63:0]), CHAL_W'(64'h11));
    tick();
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("bp_next_word", CHAL_W'(global_challenges[63:0]), CHAL_W'(64'h22));
    // Ack coincident with the strobe is ignored, then honoured in WAIT_ACK
    molecule_ready = 1'b1;
    tick();
    check("issue_ack_ignored", CHAL_W'(challenge_count), CHAL_W'(3));
    tick();
    check("wait_ack_taken", CHAL_W'(challenge_count), CHAL_W'(4));
    tick();
    tick();
    molecule_ready = 1'b0;
    check("fill_ack_ignored", CHAL_W'(challenge_count), CHAL_W'(4));

    // Reset after 5 of 8 words
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      word_in    = 32'hE0 + 32'(i);
      tick();
    end
    word_valid = 1'b0;
    reset_n    = 1'b0;
    tick();
    check("midrst_chal", global_challenges, '0);
    check("midrst_count", CHAL_W'(challenge_count), '0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word_valid = 1'b1;
      word_in    = 32'hF0 + 32'(i);
      word_last  = (i == 7);
      exp_mol[i*32 +: 32] = 32'hF0 + 32'(i);
      tick();
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    check("midrst_molecule", CHAL_W'(global_challenges[255:0]), CHAL_W'(exp_mol));
    check("midrst_high_zero", CHAL_W'(global_challenges[1023:256]), '0);
    tick();
    molecule_ready = 1'b1;
    tick();
    molecule_ready = 1'b0;
    check("midrst_count_after", CHAL_W'(challenge_count), CHAL_W'(1));

    // Count wrap from 0xFFFF
    word_valid = 1'b1;
    word_in    = 32'h99;
    word_last  = 1'b1;
    tick();
    word_valid = 1'b0;
    word_last  = 1'b0;
    tick();
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    check("wrap_preload", CHAL_W'(challenge_count), CHAL_W'(16'hFFFF));
    molecule_ready = 1'b1;
    tick();
    molecule_ready = 1'b0;
    check("wrap_zero", CHAL_W'(challenge_count), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
